mshr_hazard_scoreboard: RTL and testbench



---
 rtl/mshr_hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_mshr_hazard_scoreboard.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_hazard_scoreboard.sv
// Load-miss scoreboard: tracks the rd of each outstanding MSHR, stalls execute on
// RAW hazards against pending misses, and suppresses writeback of WAW-stale fills.
module mshr_hazard_scoreboard #(
    parameter int NUM_MSHR = 4,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_reg1,
    input  logic [4:0]      ex_reg2,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_rd,
    output logic            alloc_ready,
    output logic [ID_W-1:0] alloc_id,
    input  logic            fill_valid,
    input  logic [ID_W-1:0] fill_id,
    output logic            fill_wb_en,
    output logic [4:0]      fill_rd,
    output logic            stall,
    output logic [3:0]      pending_cnt,
    output logic [31:0]     stall_cycles,
    output logic            protocol_err
);

    logic [NUM_MSHR-1:0] live_q, live_d;
    logic [NUM_MSHR-1:0] stale_q, stale_d;
    logic [4:0]          rd_q [NUM_MSHR];
    logic [4:0]          rd_d [NUM_MSHR];
    logic [3:0]          pending_q, pending_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic                perr_q, perr_d;

    logic free_found;
    logic fill_hit;
    logic fill_stale;
    logic alloc_acc;
    logic fill_ok;
    logic raw_hit;
    logic bypass_hit;

    // Free-entry search uses registered state only, so a slot freed by a fill
    // this cycle is not offered until the next cycle.
    always_comb begin
        alloc_ready = ~&live_q;
        alloc_id    = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (!live_q[i] && !free_found) begin
                alloc_id   = ID_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Matching by loop keeps out-of-range fill ids harmless (no hit, rd reads 0).
    always_comb begin
        fill_hit   = 1'b0;
        fill_stale = 1'b0;
        fill_rd    = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (fill_id == ID_W'(i)) begin
                fill_hit   = live_q[i];
                fill_stale = stale_q[i];
                fill_rd    = rd_q[i];
            end
        end
    end

    assign alloc_acc  = alloc_valid && alloc_ready;
    assign fill_ok    = fill_valid && fill_hit;
    assign fill_wb_en = fill_ok && !fill_stale && (fill_rd != 5'd0);

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (live_q[i] && !stale_q[i] && (rd_q[i] != 5'd0) &&
                ((rd_q[i] == ex_reg1) || (rd_q[i] == ex_reg2))) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign bypass_hit = alloc_acc && (alloc_rd != 5'd0) &&
                        ((alloc_rd == ex_reg1) || (alloc_rd == ex_reg2));
    assign stall      = ex_valid && (raw_hit || bypass_hit);

    always_comb begin
        live_d      = live_q;
        stale_d     = stale_q;
        rd_d        = rd_q;
        pending_d   = pending_q + {3'b000, alloc_acc} - {3'b000, fill_ok};
        stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        perr_d      = perr_q || (alloc_valid && !alloc_ready) || (fill_valid && !fill_hit);
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (fill_ok && (fill_id == ID_W'(i))) begin
                live_d[i] = 1'b0;
            end
            // A younger load to the same rd makes older fills unable to write back.
            if (alloc_acc && (alloc_rd != 5'd0) && live_q[i] && (rd_q[i] == alloc_rd) &&
                (alloc_id != ID_W'(i))) begin
                stale_d[i] = 1'b1;
            end
            if (alloc_acc && (alloc_id == ID_W'(i))) begin
                live_d[i]  = 1'b1;
                stale_d[i] = 1'b0;
                rd_d[i]    = alloc_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= '0;
            stale_q     <= '0;
            pending_q   <= '0;
            stall_cnt_q <= '0;
            perr_q      <= 1'b0;
            for (int i = 0; i < NUM_MSHR; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            live_q      <= live_d;
            stale_q     <= stale_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            perr_q      <= perr_d;
            for (int i = 0; i < NUM_MSHR; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    assign pending_cnt  = pending_q;
    assign stall_cycles = stall_cnt_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_mshr_hazard_scoreboard.sv
// Bench for mshr_hazard_scoreboard: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_mshr_hazard_scoreboard;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_reg1;
    logic [4:0]  ex_reg2;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [1:0]  alloc_id;
    logic        fill_valid;
    logic [1:0]  fill_id;
    logic        fill_wb_en;
    logic [4:0]  fill_rd;
    logic        stall;
    logic [3:0]  pending_cnt;
    logic [31:0] stall_cycles;
    logic        protocol_err;

    int tests = 0;
    int fails = 0;

    mshr_hazard_scoreboard #(.NUM_MSHR(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .fill_valid(fill_valid), .fill_id(fill_id),
        .fill_wb_en(fill_wb_en), .fill_rd(fill_rd),
        .stall(stall), .pending_cnt(pending_cnt),
        .stall_cycles(stall_cycles), .protocol_err(protocol_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a table of outstanding misses
    bit          m_live  [N];
    bit          m_stale [N];
    logic [4:0]  m_rd    [N];
    bit          m_perr;
    logic [31:0] m_sc;

    function automatic bit m_ready();
        for (int i = 0; i < N; i++) if (!m_live[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_id();
        for (int i = 0; i < N; i++) if (!m_live[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_live[i] ? 1 : 0;
        return c;
    endfunction

    function automatic bit m_fill_ok();
        return fill_valid && (int'(fill_id) < N) && m_live[fill_id];
    endfunction

    function automatic bit m_wb();
        return m_fill_ok() && !m_stale[fill_id] && (m_rd[fill_id] != 5'd0);
    endfunction

    function automatic bit m_stall();
        bit hit = 1'b0;
        if (!ex_valid) return 1'b0;
        for (int i = 0; i < N; i++)
            if (m_live[i] && !m_stale[i] && m_rd[i] != 0 && (m_rd[i] == ex_reg1 || m_rd[i] == ex_reg2))
                hit = 1'b1;
        if (alloc_valid && m_ready() && alloc_rd != 0 && (alloc_rd == ex_reg1 || alloc_rd == ex_reg2))
            hit = 1'b1;
        return hit;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_live[i] = 1'b0; m_stale[i] = 1'b0; m_rd[i] = 5'd0;
            end
            m_perr = 1'b0;
            m_sc   = 32'd0;
        end else begin
            bit         rdy, fok, st;
            logic [1:0] id;
            rdy = m_ready(); id = m_id(); fok = m_fill_ok(); st = m_stall();
            if ((alloc_valid && !rdy) || (fill_valid && !fok)) m_perr = 1'b1;
            if (st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (fok) m_live[fill_id] = 1'b0;
            if (alloc_valid && rdy) begin
                for (int i = 0; i < N; i++)
                    if (alloc_rd != 0 && m_rd[i] == alloc_rd && m_live[i]) m_stale[i] = 1'b1;
                m_live[id] = 1'b1; m_stale[id] = 1'b0; m_rd[id] = alloc_rd;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmp_alloc_ready", 32'(alloc_ready), 32'(m_ready()));
        chk("cmp_alloc_id", 32'(alloc_id), 32'(m_id()));
        chk("cmp_fill_wb_en", 32'(fill_wb_en), 32'(m_wb()));
        chk("cmp_fill_rd", 32'(fill_rd), 32'(m_rd[fill_id]));
        chk("cmp_stall", 32'(stall), 32'(m_stall()));
        chk("cmp_pending", 32'(pending_cnt), 32'(m_count()));
        chk("cmp_stall_cycles", stall_cycles, m_sc);
        chk("cmp_protocol_err", 32'(protocol_err), 32'(m_perr));
    end

    // Driver tasks
    task automatic idle();
        ex_valid = 0; ex_reg1 = 0; ex_reg2 = 0;
        alloc_valid = 0; alloc_rd = 0; fill_valid = 0; fill_id = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc(); rst = 1; idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic alloc(input logic [4:0] rd);
        alloc_valid = 1; alloc_rd = rd;
    endtask

    task automatic fill(input logic [1:0] id);
        fill_valid = 1; fill_id = id;
    endtask

    initial begin
        rst = 1; idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_id", 32'(alloc_id), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fill_wb_en", 32'(fill_wb_en), 32'd0);
        chk("rst_fill_rd", 32'(fill_rd), 32'd0);
        chk("rst_pending", 32'(pending_cnt), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        rst = 0;

        // Basic miss: alloc, RAW stall, fill releases
        cyc(); alloc(5); #2 chk("t1_alloc_id", 32'(alloc_id), 32'd0);
        cyc(); alloc_valid = 0; ex_valid = 1; ex_reg1 = 5;
        #2 chk("t1_pending", 32'(pending_cnt), 32'd1);
        chk("t1_stall", 32'(stall), 32'd1);
        cyc();
        cyc(); fill(0);
        #2 chk("t1_wb", 32'(fill_wb_en), 32'd1);
        chk("t1_fill_rd", 32'(fill_rd), 32'd5);
        chk("t1_stall_fill", 32'(stall), 32'd1);
        cyc(); fill_valid = 0;
        #2 chk("t1_stall_off", 32'(stall), 32'd0);
        chk("t1_stall_cycles", stall_cycles, 32'd3);
        chk("t1_pending0", 32'(pending_cnt), 32'd0);
        ex_valid = 0;

        // Fill all entries, then overflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(); alloc(5'(i + 1));
            #2 chk("t2_alloc_id", 32'(alloc_id), 32'(i));
        end
        cyc(); alloc(6);
        #2 chk("t2_full_ready", 32'(alloc_ready), 32'd0);
        chk("t2_full_pending", 32'(pending_cnt), 32'd4);
        cyc(); alloc_valid = 0;
        #2 chk("t2_perr", 32'(protocol_err), 32'd1);
        chk("t2_pending_hold", 32'(pending_cnt), 32'd4);

        // WAW: older fill to the same rd must not write back
        do_reset();
        cyc(); alloc(7); #2 chk("t3_id0", 32'(alloc_id), 32'd0);
        cyc(); alloc(7); #2 chk("t3_id1", 32'(alloc_id), 32'd1);
        cyc(); alloc_valid = 0; ex_valid = 1; ex_reg1 = 7; fill(0);
        #2 chk("t3_stale_wb", 32'(fill_wb_en), 32'd0);
        chk("t3_stall", 32'(stall), 32'd1);
        cyc(); fill(1);
        #2 chk("t3_young_wb", 32'(fill_wb_en), 32'd1);
        chk("t3_stall2", 32'(stall), 32'd1);
        cyc(); fill_valid = 0;
        #2 chk("t3_stall_off", 32'(stall), 32'd0);
        ex_valid = 0; ex_reg1 = 0;

        // Same-cycle bypass, with and without a live execute slot
        cyc(); ex_valid = 1; ex_reg2 = 9; alloc(9);
        #2 chk("t4_bypass", 32'(stall), 32'd1);
        cyc(); alloc_valid = 0; ex_valid = 0; fill(0);
        #2 chk("t4_masked", 32'(stall), 32'd0);
        cyc(); fill_valid = 0; alloc(9);
        #2 chk("t4_bypass_masked", 32'(stall), 32'd0);
        // Fill of id0 with a concurrent alloc: freed slot not reused this cycle
        cyc(); alloc(0); fill(0);
        #2 chk("t4_no_reuse", 32'(alloc_id), 32'd1);
        chk("t4_wb", 32'(fill_wb_en), 32'd1);
        // x0 destination
        cyc(); alloc_valid = 0; ex_valid = 1; ex_reg1 = 0; ex_reg2 = 0; fill(1);
        #2 chk("t5_x0_stall", 32'(stall), 32'd0);
        chk("t5_x0_wb", 32'(fill_wb_en), 32'd0);
        chk("t5_reuse", 32'(alloc_id), 32'd0);
        cyc(); fill_valid = 0; ex_valid = 0;
        #2 chk("t5_pending0", 32'(pending_cnt), 32'd0);

        // Illegal fill, then async reset mid-miss
        do_reset();
        cyc(); fill(2);
        #2 chk("t6_bad_wb", 32'(fill_wb_en), 32'd0);
        cyc(); fill_valid = 0; alloc(12);
        #2 chk("t6_perr", 32'(protocol_err), 32'd1);
        cyc(); alloc(13);
        cyc(); alloc_valid = 0;
        #2 chk("t6_pending2", 32'(pending_cnt), 32'd2);
        rst = 1;
        #1 chk("t6_rst_pending", 32'(pending_cnt), 32'd0);
        chk("t6_rst_perr", 32'(protocol_err), 32'd0);
        chk("t6_rst_ready", 32'(alloc_ready), 32'd1);
        cyc(); rst = 0; fill(0);
        #2 chk("t6_late_wb", 32'(fill_wb_en), 32'd0);
        cyc(); fill_valid = 0;
        #2 chk("t6_late_perr", 32'(protocol_err), 32'd1);

        // Random traffic, checked every cycle by the compare process
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                idle(); rst = 1;
                cyc(); rst = 0;
            end
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_reg1     = 5'($urandom_range(0, 7));
            ex_reg2     = 5'($urandom_range(0, 7));
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_rd    = 5'($urandom_range(0, 7));
            fill_valid  = ($urandom_range(0, 2) == 0);
            fill_id     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    logic [1:0] cand;
                    cand = 2'($urandom_range(0, 3));
                    if (m_live[cand]) fill_id = cand;
                end
            end
        end
        cyc(); idle();
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
